// File: rtl/braille_pkg.sv
// Shared types and default sizing for the braille actuator pulse sequencer.
package braille_pkg;
  localparam int unsigned NUM_DOTS_DEF = 8;
  localparam int unsigned CNT_W_DEF    = 16;

  typedef enum logic [2:0] {IDLE, SCAN, DEAD, PULSE, DONE} seq_state_t;
endpackage

// File: rtl/actuator_pulse_sequencer_if.sv
// Pattern handshake and coil/status bundle between the cell controller and the sequencer.
interface actuator_pulse_sequencer_if
  import braille_pkg::*;
#(
  parameter int unsigned NUM_DOTS = NUM_DOTS_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
);
  logic [NUM_DOTS-1:0] pattern_i;
  logic                pattern_valid_i;
  logic                pattern_ready_o;
  logic                force_all_i;
  logic [CNT_W-1:0]    pulse_width_i;
  logic [CNT_W-1:0]    dead_time_i;
  logic [NUM_DOTS-1:0] coil_pos_o;
  logic [NUM_DOTS-1:0] coil_neg_o;
  logic [NUM_DOTS-1:0] dot_state_o;
  logic                busy_o;
  logic                done_o;

  modport master (
    output pattern_i, pattern_valid_i, force_all_i, pulse_width_i, dead_time_i,
    input  pattern_ready_o, coil_pos_o, coil_neg_o, dot_state_o, busy_o, done_o
  );

  modport slave (
    input  pattern_i, pattern_valid_i, force_all_i, pulse_width_i, dead_time_i,
    output pattern_ready_o, coil_pos_o, coil_neg_o, dot_state_o, busy_o, done_o
  );
endinterface

// File: rtl/actuator_pulse_sequencer_pulse_timer.sv
// Loadable saturating down-counter timing both the dead interval and the coil pulse.
module pulse_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // A load of N gives N cycles; the Nth is the one where the count reads 1.
  assign expired = (count_q <= CNT_W'(1));
endmodule

// File: rtl/actuator_pulse_sequencer.sv
// Converts a cell dot pattern into one-dot-at-a-time timed H-bridge pulses, tracking committed dot state.
module actuator_pulse_sequencer
  import braille_pkg::*;
#(
  parameter int unsigned NUM_DOTS = NUM_DOTS_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input logic                        wb_clk_i,
  input logic                        rst_n_i,
  actuator_pulse_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;

  seq_state_t          state;
  logic [IDX_W-1:0]    idx;
  logic [NUM_DOTS-1:0] pat_q;
  logic [NUM_DOTS-1:0] mask_q;
  logic [CNT_W-1:0]    w_q;
  logic [CNT_W-1:0]    d_q;
  logic [NUM_DOTS-1:0] coil_pos_q;
  logic [NUM_DOTS-1:0] coil_neg_q;
  logic [NUM_DOTS-1:0] dot_state_q;
  logic                done_q;

  logic                timer_load;
  logic [CNT_W-1:0]    timer_value;
  logic                timer_expired;
  logic                last_dot;
  logic [NUM_DOTS-1:0] dot_sel;

  assign last_dot = (idx == IDX_W'(NUM_DOTS - 1));
  assign dot_sel  = NUM_DOTS'(1) << idx;

  // The timer is loaded on the same edge the FSM enters DEAD or PULSE.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = w_q;
    case (state)
      SCAN: begin
        timer_load  = mask_q[idx];
        timer_value = (d_q == '0) ? w_q : d_q;
      end
      DEAD:    timer_load = timer_expired;
      default: timer_load = 1'b0;
    endcase
  end

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (wb_clk_i),
    .rst_n   (rst_n_i),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      idx         <= '0;
      pat_q       <= '0;
      mask_q      <= '0;
      w_q         <= '0;
      d_q         <= '0;
      coil_pos_q  <= '0;
      coil_neg_q  <= '0;
      dot_state_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q     <= 1'b0;
          coil_pos_q <= '0;
          coil_neg_q <= '0;
          if (bus.pattern_valid_i) begin
            pat_q  <= bus.pattern_i;
            w_q    <= (bus.pulse_width_i == '0) ? CNT_W'(1) : bus.pulse_width_i;
            d_q    <= bus.dead_time_i;
            mask_q <= bus.force_all_i ? '1 : (bus.pattern_i ^ dot_state_q);
            idx    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (mask_q[idx]) begin
            if (d_q == '0) begin
              coil_pos_q <= dot_sel & pat_q;
              coil_neg_q <= dot_sel & ~pat_q;
              state      <= PULSE;
            end else begin
              state <= DEAD;
            end
          end else if (last_dot) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DEAD: begin
          if (timer_expired) begin
            coil_pos_q <= dot_sel & pat_q;
            coil_neg_q <= dot_sel & ~pat_q;
            state      <= PULSE;
          end
        end
        PULSE: begin
          if (timer_expired) begin
            coil_pos_q       <= '0;
            coil_neg_q       <= '0;
            dot_state_q[idx] <= pat_q[idx];
            if (last_dot) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pattern_ready_o = (state == IDLE);
  assign bus.busy_o          = (state != IDLE);
  assign bus.coil_pos_o      = coil_pos_q;
  assign bus.coil_neg_o      = coil_neg_q;
  assign bus.dot_state_o     = dot_state_q;
  assign bus.done_o          = done_q;
endmodule

// File: tb/tb_actuator_pulse_sequencer.sv
// Directed bench for actuator_pulse_sequencer: sequence timing, coil activity, reset and long-pulse behaviour.
module tb_actuator_pulse_sequencer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   accept_cnt = 0;

  actuator_pulse_sequencer_if #(.NUM_DOTS(8), .CNT_W(16)) bus ();

  actuator_pulse_sequencer #(.NUM_DOTS(8), .CNT_W(16)) dut (
    .wb_clk_i (clk),
    .rst_n_i  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle coil invariants and accept counting, sampled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] c;
    c = {bus.coil_pos_o, bus.coil_neg_o};
    check("coil_onehot0", {31'b0, (c & (c - 16'd1)) == 16'd0}, 32'd1);
    check("pos_neg_excl", {24'b0, bus.coil_pos_o & bus.coil_neg_o}, 32'd0);
    if (bus.pattern_valid_i && bus.pattern_ready_o) accept_cnt++;
  end

  task automatic offer(input logic [7:0] pat, input logic frc,
                       input logic [15:0] w, input logic [15:0] d);
    @(posedge clk); #1;
    bus.pattern_i       = pat;
    bus.force_all_i     = frc;
    bus.pulse_width_i   = w;
    bus.dead_time_i     = d;
    bus.pattern_valid_i = 1'b1;
  endtask

  // Consumes the accept edge, then counts edges until done_o is seen.
  task automatic run_seq(input bit hold, input int budget, output int edges,
                         output int pos_on, output int neg_on,
                         output logic [7:0] pos_seen, output logic [7:0] neg_seen);
    edges = -1; pos_on = 0; neg_on = 0; pos_seen = '0; neg_seen = '0;
    @(posedge clk); #1;
    if (!hold) bus.pattern_valid_i = 1'b0;
    check("busy_after_accept", {31'b0, bus.busy_o}, 32'd1);
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      pos_on   += $countones(bus.coil_pos_o);
      neg_on   += $countones(bus.coil_neg_o);
      pos_seen |= bus.coil_pos_o;
      neg_seen |= bus.coil_neg_o;
      if (bus.done_o) begin
        edges = n;
        bus.pattern_valid_i = 1'b0;
        break;
      end
    end
    if (edges < 0) bus.pattern_valid_i = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, bus.done_o}, 32'd0);
    check("ready_after_done", {31'b0, bus.pattern_ready_o}, 32'd1);
  endtask

  initial begin
    int edges, pos_on, neg_on, acc0;
    logic [7:0] pos_seen, neg_seen;

    rst_n = 1'b0;
    bus.pattern_i = '0; bus.pattern_valid_i = 1'b0; bus.force_all_i = 1'b0;
    bus.pulse_width_i = '0; bus.dead_time_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.pattern_ready_o}, 32'd1);
    check("rst_busy",  {31'b0, bus.busy_o}, 32'd0);
    check("rst_done",  {31'b0, bus.done_o}, 32'd0);
    check("rst_coils", {16'b0, bus.coil_pos_o, bus.coil_neg_o}, 32'd0);
    check("rst_dot_state", {24'b0, bus.dot_state_o}, 32'd0);
    rst_n = 1'b1;

    // A5 from zero: 4 changed dots, D=2, W=3 -> done 28 edges after accept.
    offer(8'hA5, 1'b0, 16'd3, 16'd2);
    run_seq(1'b0, 200, edges, pos_on, neg_on, pos_seen, neg_seen);
    check("a5_done_edges", edges, 32'd28);
    check("a5_pos_seen", {24'b0, pos_seen}, 32'hA5);
    check("a5_neg_seen", {24'b0, neg_seen}, 32'h00);
    check("a5_pos_cycles", pos_on, 32'd12);
    check("a5_neg_cycles", neg_on, 32'd0);
    check("a5_dot_state", {24'b0, bus.dot_state_o}, 32'hA5);

    // Same pattern again: empty mask still scans all 8 dots.
    offer(8'hA5, 1'b0, 16'd3, 16'd2);
    run_seq(1'b0, 200, edges, pos_on, neg_on, pos_seen, neg_seen);
    check("same_done_edges", edges, 32'd8);
    check("same_coil_cycles", pos_on + neg_on, 32'd0);
    check("same_dot_state", {24'b0, bus.dot_state_o}, 32'hA5);

    // Forced 5A, D=0, W=0 (treated as 1), valid held high throughout.
    acc0 = accept_cnt;
    offer(8'h5A, 1'b1, 16'd0, 16'd0);
    run_seq(1'b1, 200, edges, pos_on, neg_on, pos_seen, neg_seen);
    check("force_done_edges", edges, 32'd16);
    check("force_pos_seen", {24'b0, pos_seen}, 32'h5A);
    check("force_neg_seen", {24'b0, neg_seen}, 32'hA5);
    check("force_coil_cycles", pos_on + neg_on, 32'd8);
    check("force_dot_state", {24'b0, bus.dot_state_o}, 32'h5A);
    check("held_valid_accepts", accept_cnt - acc0, 32'd1);

    // Lower dot 3 only (52 vs 5A) with a long pulse, then reset mid-pulse.
    offer(8'h52, 1'b0, 16'd10, 16'd0);
    @(posedge clk); #1;
    bus.pattern_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("dot3_pulse_neg", {24'b0, bus.coil_neg_o}, 32'h08);
    check("dot3_pulse_pos", {24'b0, bus.coil_pos_o}, 32'h00);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_coils", {16'b0, bus.coil_pos_o, bus.coil_neg_o}, 32'd0);
    check("midrst_dot_state", {24'b0, bus.dot_state_o}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", {31'b0, bus.pattern_ready_o}, 32'd1);
    check("midrst_busy", {31'b0, bus.busy_o}, 32'd0);

    // Maximum pulse width on one changed dot: 65535 coil-on cycles.
    offer(8'h01, 1'b0, 16'hFFFF, 16'd0);
    run_seq(1'b0, 70000, edges, pos_on, neg_on, pos_seen, neg_seen);
    check("long_done_edges", edges, 32'd65543);
    check("long_pos_cycles", pos_on, 32'd65535);
    check("long_neg_cycles", neg_on, 32'd0);
    check("long_dot_state", {24'b0, bus.dot_state_o}, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
